// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier pipeline.
package booth_pkg;

  localparam int BOOTH_PIPE_STAGES = 3;

  // Digit select: zero is all-clear; neg combines with one/two for -1A/-2A.
  typedef struct packed {
    logic neg;
    logic two;
    logic one;
  } booth_digit_t;

  function automatic int booth_digits(input int width);
    return (width + 2) / 2;
  endfunction

  function automatic booth_digit_t booth_encode(input logic [2:0] win);
    booth_digit_t d;
    d = '0;
    case (win)
      3'b001, 3'b010: d.one = 1'b1;
      3'b011:         d.two = 1'b1;
      3'b100:         begin d.two = 1'b1; d.neg = 1'b1; end
      3'b101, 3'b110: begin d.one = 1'b1; d.neg = 1'b1; end
      default:        d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_mul_pipe_if.sv
// Operand/product handshake bundle for booth_mul_pipe.
interface booth_mul_pipe_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_prod, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_prod, out_tag
  );
endinterface

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product: one's complement form plus negate bit.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]         win,
  input  logic [WIDTH+1:0]   a_ext,
  output logic [2*WIDTH-1:0] pp,
  output logic               neg
);
  localparam int PW = 2 * WIDTH;
  localparam int EW = WIDTH + 2;

  booth_digit_t  dig;
  logic [PW-1:0] a_wide;

  always_comb begin
    dig    = booth_encode(win);
    a_wide = {{(PW-EW){a_ext[EW-1]}}, a_ext};
    pp     = '0;
    if (dig.two)      pp = a_wide << 1;
    else if (dig.one) pp = a_wide;
    // The +1 that completes the negation is folded into the reduction tree.
    if (dig.neg)      pp = ~pp;
    neg = dig.neg;
  end
endmodule

// File: rtl/booth_mul_pipe.sv
// 3-stage radix-4 Booth multiplier: PP generation, carry-save reduction, final add.
module booth_mul_pipe
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  booth_mul_pipe_if.slave  bus
);
  localparam int EW = WIDTH + 2;
  localparam int PW = 2 * WIDTH;
  localparam int ND = booth_digits(WIDTH);
  localparam int ST = BOOTH_PIPE_STAGES;

  logic                   advance;
  logic [ST:1]            vld_pipe;
  logic [EW-1:0]          a_ext, b_ext;
  logic [EW:0]            b_win;
  logic [ND-1:0][PW-1:0]  pp, s1_pp;
  logic [ND-1:0]          neg, s1_neg;
  logic                   s1_signed;
  logic [TAG_W-1:0]       s1_tag, s2_tag, tag_q;
  logic [PW-1:0]          nvec, csa_sum, csa_carry, csa_x, csa_t;
  logic [PW-1:0]          s2_sum, s2_carry, prod_q;

  assign advance       = !(vld_pipe[ST] && !bus.out_ready);
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_pipe[ST];
  assign bus.out_prod  = prod_q;
  assign bus.out_tag   = tag_q;

  // Two extra bits let unsigned operands look like non-negative signed values.
  assign a_ext = {{2{bus.in_signed & bus.in_a[WIDTH-1]}}, bus.in_a};
  assign b_ext = {{2{bus.in_signed & bus.in_b[WIDTH-1]}}, bus.in_b};
  assign b_win = {b_ext, 1'b0};

  generate
    for (genvar g = 0; g < ND; g++) begin : g_pp
      booth_pp_gen #(.WIDTH(WIDTH)) u_pp (
        .win   (b_win[2*g+2 -: 3]),
        .a_ext (a_ext),
        .pp    (pp[g]),
        .neg   (neg[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n)       vld_pipe <= '0;
    else if (advance) vld_pipe <= {vld_pipe[ST-1:1], bus.in_valid};
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_pp     <= pp;
      s1_neg    <= neg;
      s1_signed <= bus.in_signed;
      s1_tag    <= bus.in_tag;
    end
  end

  // Signed operands sign-fill the top window, so its digit must be zero.
  always_ff @(posedge clk) begin
    if (rst_n && vld_pipe[1])
      assert (!s1_signed || (s1_pp[ND-1] == '0 && !s1_neg[ND-1]));
  end

  // Linear 3:2 compressor chain; negate bits ride in the initial carry vector.
  always_comb begin
    nvec      = '0;
    csa_x     = '0;
    csa_t     = '0;
    for (int i = 0; i < ND; i++) nvec[2*i] = s1_neg[i];
    csa_sum   = s1_pp[0];
    csa_carry = nvec;
    for (int i = 1; i < ND; i++) begin
      csa_x     = s1_pp[i] << (2 * i);
      csa_t     = csa_sum ^ csa_carry ^ csa_x;
      csa_carry = ((csa_sum & csa_carry) | (csa_sum & csa_x) | (csa_carry & csa_x)) << 1;
      csa_sum   = csa_t;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s2_sum   <= csa_sum;
      s2_carry <= csa_carry;
      s2_tag   <= s1_tag;
    end
  end

  // Output only loads on real products so bubbles leave the last result visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q <= '0;
      tag_q  <= '0;
    end else if (advance && vld_pipe[ST-1]) begin
      prod_q <= s2_sum + s2_carry;
      tag_q  <= s2_tag;
    end
  end
endmodule

// File: tb/tb_booth_mul_pipe.sv
// Directed bench for booth_mul_pipe: corners, latency, backpressure, reset, short random burst.
module tb_booth_mul_pipe;
  localparam int W  = 8;
  localparam int TW = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  booth_mul_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  booth_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]    va [64];
  logic [W-1:0]    vb [64];
  logic            vs [64];
  logic [TW-1:0]   vt [64];
  logic [2*W-1:0]  ep [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [TW-1:0] t, input logic [2*W-1:0] p);
    va[i] = a; vb[i] = b; vs[i] = s; vt[i] = t; ep[i] = p;
  endtask

  // Streams n vectors in, drains n products, optionally stalling after first output.
  task automatic run_burst(input string name, input int n, input int stall_len, input bit rnd);
    int  sent, got, cyc, stall, extra;
    bit  seen, fin, fout;
    sent = 0; got = 0; cyc = 0; stall = 0; seen = 1'b0;
    while (got < n && cyc < 2000) begin
      if (!seen && bus.out_valid && stall_len > 0) begin
        seen  = 1'b1;
        stall = stall_len;
      end
      bus.out_ready = (stall > 0) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      bus.in_valid  = (sent < n);
      if (sent < n) begin
        bus.in_a = va[sent]; bus.in_b = vb[sent];
        bus.in_signed = vs[sent]; bus.in_tag = vt[sent];
      end
      #1;
      if (stall > 0) begin
        check({name, "_stall_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({name, "_stall_prod"}, 32'(bus.out_prod), 32'(ep[got]));
        check({name, "_stall_tag"}, 32'(bus.out_tag), 32'(vt[got]));
        stall--;
      end
      fin  = bus.in_valid && bus.in_ready;
      fout = bus.out_valid && bus.out_ready;
      if (fout) begin
        check({name, "_prod"}, 32'(bus.out_prod), 32'(ep[got]));
        check({name, "_tag"}, 32'(bus.out_tag), 32'(vt[got]));
        got++;
      end
      if (fin) sent++;
      tick();
      cyc++;
    end
    check({name, "_count"}, 32'(got), 32'(n));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (bus.out_valid) extra++;
      tick();
    end
    check({name, "_no_extra"}, 32'(extra), 32'd0);
  endtask

  // One transaction on an idle pipe: product must show exactly 3 edges after acceptance.
  task automatic single(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [TW-1:0] t, input logic [2*W-1:0] p);
    bus.out_ready = 1'b1;
    bus.in_a = a; bus.in_b = b; bus.in_signed = s; bus.in_tag = t;
    bus.in_valid = 1'b1;
    #1;
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check({name, "_early"}, 32'(bus.out_valid), 32'd0);
    tick();
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_prod"}, 32'(bus.out_prod), 32'(p));
    check({name, "_tag"}, 32'(bus.out_tag), 32'(t));
    tick();
    check({name, "_drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [2*W-1:0] sa, sb;
    int             stale;
    errors = 0;
    checks = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_signed = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_prod", 32'(bus.out_prod), 32'd0);
    check("rst_out_tag", 32'(bus.out_tag), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    single("lat_s8080", 8'h80, 8'h80, 1'b1, 4'd1, 16'h4000);
    single("lat_s807f", 8'h80, 8'h7F, 1'b1, 4'd2, 16'hC080);
    single("lat_sffff", 8'hFF, 8'hFF, 1'b1, 4'd3, 16'h0001);
    single("lat_uffff", 8'hFF, 8'hFF, 1'b0, 4'd4, 16'hFE01);
    single("lat_u8002", 8'h80, 8'h02, 1'b0, 4'd5, 16'h0100);

    // Back-to-back with alternating modes on identical operands.
    set_vec(0, 8'hFF, 8'hFF, 1'b1, 4'h1, 16'h0001);
    set_vec(1, 8'hFF, 8'hFF, 1'b0, 4'h2, 16'hFE01);
    set_vec(2, 8'h80, 8'h7F, 1'b1, 4'h3, 16'hC080);
    set_vec(3, 8'h80, 8'h7F, 1'b0, 4'h4, 16'h3F80);
    set_vec(4, 8'h03, 8'hFD, 1'b1, 4'h5, 16'hFFF7);
    set_vec(5, 8'h03, 8'hFD, 1'b0, 4'h6, 16'h02F7);
    set_vec(6, 8'h80, 8'h80, 1'b1, 4'h7, 16'h4000);
    set_vec(7, 8'h80, 8'h80, 1'b0, 4'h8, 16'h4000);
    run_burst("alt", 8, 0, 1'b0);

    // Backpressure: tags 0..5, five stalled cycles after the first product.
    set_vec(0, 8'h7F, 8'h7F, 1'b1, 4'd0, 16'h3F01);
    set_vec(1, 8'h80, 8'h01, 1'b1, 4'd1, 16'hFF80);
    set_vec(2, 8'h12, 8'h34, 1'b0, 4'd2, 16'h03A8);
    set_vec(3, 8'h00, 8'h80, 1'b1, 4'd3, 16'h0000);
    set_vec(4, 8'h03, 8'hFD, 1'b1, 4'd4, 16'hFFF7);
    set_vec(5, 8'hFF, 8'h80, 1'b0, 4'd5, 16'h7F80);
    run_burst("bp", 6, 5, 1'b0);

    // Reset with three transactions in flight.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_a = 8'h11 + 8'(i); bus.in_b = 8'h22; bus.in_signed = 1'b0;
      bus.in_tag = 4'(9 + i); bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_prod", 32'(bus.out_prod), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.out_valid) stale++;
      tick();
    end
    check("mid_rst_stale", 32'(stale), 32'd0);
    single("post_rst", 8'h12, 8'h34, 1'b0, 4'd7, 16'h03A8);

    // Short random burst with random consumer readiness.
    for (int i = 0; i < 40; i++) begin
      va[i] = 8'($urandom); vb[i] = 8'($urandom);
      vs[i] = 1'($urandom_range(0, 1)); vt[i] = 4'(i);
      sa = vs[i] ? {{W{va[i][W-1]}}, va[i]} : {{W{1'b0}}, va[i]};
      sb = vs[i] ? {{W{vb[i][W-1]}}, vb[i]} : {{W{1'b0}}, vb[i]};
      ep[i] = sa * sb;
    end
    run_burst("rnd", 40, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
